serial_frame_tx: RTL and testbench



---
 rtl/serial_link_pkg.sv | 8 +
 rtl/sync_fifo.sv | 33 +++
 rtl/serial_frame_tx.sv | 92 +++++++++
 tb/tb_serial_frame_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: frame constants and transmitter state encoding shared by both ends of the serial link
package serial_link_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_TRAIN} state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: buffered byte stream to NRZ start/data/parity/stop frames, with a 1010 training mode
module serial_frame_tx import serial_link_pkg::*; #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       train,
    output logic       serial_out,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_t state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, fifo_dout;
    logic par, trn_lvl, full, empty, pop, bit_end, line_d;
    assign s_tready = !rst && !full;
    assign bit_end = baud_cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = (state != ST_IDLE) || !empty;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(s_tvalid && s_tready),
        .din(s_tdata),
        .pop(pop),
        .dout(fifo_dout),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        state_n = state;
        pop = 1'b0;
        line_d = IDLE_LEVEL;
        case (state)
            ST_IDLE: begin
                state_n = train ? ST_TRAIN : (!empty ? ST_START : ST_IDLE);
                pop = !train && !empty;
            end
            ST_START: begin
                line_d = START_BIT;
                state_n = bit_end ? ST_DATA : ST_START;
            end
            ST_DATA: begin
                line_d = shreg[7];
                if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) state_n = PARITY_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                line_d = par;
                state_n = bit_end ? ST_STOP : ST_PARITY;
            end
            ST_STOP: begin
                line_d = STOP_BIT;
                pop = bit_end && !empty && !train;
                state_n = pop ? ST_START : (bit_end ? ST_IDLE : ST_STOP);
            end
            ST_TRAIN: begin
                line_d = trn_lvl;
                state_n = (bit_end && !train && trn_lvl) ? ST_IDLE : ST_TRAIN;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // The line is registered from the current state, so it trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            trn_lvl <= 1'b0;
            serial_out <= IDLE_LEVEL;
        end else begin
            state <= state_n;
            serial_out <= line_d;
            baud_cnt <= (state_n != state || bit_end || state == ST_IDLE) ? '0 : baud_cnt + 1'b1;
            trn_lvl <= (state != ST_TRAIN) ? 1'b0 : (bit_end ? !trn_lvl : trn_lvl);
            if (pop) begin
                shreg <= fifo_dout;
                par <= ^fifo_dout;
            end else if (state == ST_DATA && bit_end) begin
                shreg <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: three configurations checked against a frame-level line model built from logged line samples
module tb_serial_frame_tx;
    localparam int NC = 4096;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0][7:0] tdata;
    logic [2:0] tvalid, train;
    wire [2:0] ready, so, busy;
    logic lg [3][NC];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < NC) for (int i = 0; i < 3; i++) lg[i][cyc] = so[i];

    serial_frame_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .s_tdata(tdata[0]), .s_tvalid(tvalid[0]), .s_tready(ready[0]),
        .train(train[0]), .serial_out(so[0]), .busy(busy[0]));
    serial_frame_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .s_tdata(tdata[1]), .s_tvalid(tvalid[1]), .s_tready(ready[1]),
        .train(train[1]), .serial_out(so[1]), .busy(busy[1]));
    serial_frame_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .PARITY_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .s_tdata(tdata[2]), .s_tvalid(tvalid[2]), .s_tready(ready[2]),
        .train(train[2]), .serial_out(so[2]), .busy(busy[2]));

    function automatic int cpb(input int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic bit pe(input int i);
        return i != 1;
    endfunction
    function automatic int flen(input int i);
        return (pe(i) ? 11 : 10) * cpb(i);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_to(input int x);
        for (int g = 0; g < NC && cyc < x; g++) tick();
    endtask

    // Returns the clock edge at which the byte is taken.
    task automatic push(input int i, input logic [7:0] d, output int t);
        tdata[i] = d;
        tvalid[i] = 1'b1;
        t = -1;
        for (int g = 0; g < 400 && t < 0; g++) begin
            if (ready[i]) t = cyc + 1;
            tick();
        end
        tvalid[i] = 1'b0;
        if (t < 0) chk("push_timeout", 0, 1);
    endtask

    task automatic check_frame(input int i, input int s, input logic [7:0] d);
        logic q[$];
        q = {1'b0};
        for (int b = 7; b >= 0; b--) q.push_back(d[b]);
        if (pe(i)) q.push_back(^d);
        q.push_back(1'b1);
        chk($sformatf("pre_frame%0d_%02h", i, d), {31'd0, lg[i][s-1]}, 1);
        for (int j = 0; j < q.size(); j++)
            for (int c = 0; c < cpb(i); c++)
                chk($sformatf("frame%0d_%02h_bit%0d_c%0d", i, d, j, c), {31'd0, lg[i][s+j*cpb(i)+c]}, {31'd0, q[j]});
    endtask

    // Training entered at edge e0, train last seen high at edge l: an even bit count ending after l.
    task automatic train_check(input int i, input int e0, input int l, output int e);
        int n = 2;
        while (e0 + n * cpb(i) <= l) n += 2;
        e = e0 + n * cpb(i);
        wait_to(e + 3);
        chk("train_pre", {31'd0, lg[i][e0]}, 1);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < cpb(i); c++)
                chk($sformatf("train_bit%0d_c%0d", k, c), {31'd0, lg[i][e0+1+k*cpb(i)+c]}, k % 2);
        chk("train_end_idle", {31'd0, lg[i][e+1]}, 1);
    endtask

    task automatic find_start(input int i, input int from, output int s);
        s = from;
        while (s < cyc && lg[i][s] !== 1'b0) s++;
        if (s >= cyc) chk("start_found", 0, 1);
    endtask

    initial begin
        #(NC * 10 - 20);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", NC);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s, e, l, pos, zeros;
        int tb[8];
        logic [7:0] q[$];
        int tq[$];
        tvalid = '0;
        train = '0;
        tdata = '0;
        repeat (3) tick();
        chk("rst_ready", {29'd0, ready}, 0);
        chk("rst_line", {29'd0, so}, 3'b111);
        chk("rst_busy", {29'd0, busy}, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {29'd0, ready}, 3'b111);

        push(0, 8'hA5, t);
        s = t + 2;
        wait_to(s + flen(0) - 2);
        chk("busy_in_stop", {31'd0, busy[0]}, 1);
        tick();
        chk("busy_after_stop", {31'd0, busy[0]}, 0);
        wait_to(s + flen(0) + 4);
        check_frame(0, s, 8'hA5);
        chk("idle_after_a5", {31'd0, lg[0][s+flen(0)]}, 1);

        for (int k = 0; k < 8; k++) push(0, 8'(k), tb[k]);
        chk("b2b_first5_back_to_back", tb[4] - tb[0], 4);
        chk("b2b_backpressure", {31'd0, tb[5] > tb[0] + 5}, 1);
        wait_to(tb[0] + 2 + 8 * flen(0) + 4);
        for (int k = 0; k < 8; k++) check_frame(0, tb[0] + 2 + k * flen(0), 8'(k));
        chk("b2b_busy_done", {31'd0, busy[0]}, 0);

        pos = cyc;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d = 8'($urandom);
            push(0, d, t);
            q.push_back(d);
            tq.push_back(t);
            repeat ($urandom_range(0, 3)) tick();
        end
        for (int g = 0; g < 2000 && busy[0]; g++) tick();
        chk("rand_busy_done", {31'd0, busy[0]}, 0);
        tick();
        for (int k = 0; k < 12; k++) begin
            find_start(0, pos, s);
            chk($sformatf("rand_latency%0d", k), {31'd0, s >= tq[k] + 2}, 1);
            check_frame(0, s, q[k]);
            pos = s + flen(0);
        end

        push(1, 8'hFF, t);
        wait_to(t + 2 + flen(1) + 3);
        check_frame(1, t + 2, 8'hFF);
        chk("np_idle_after", {31'd0, lg[1][t+2+flen(1)]}, 1);
        chk("np_busy_done", {31'd0, busy[1]}, 0);

        push(2, 8'h55, t);
        push(2, 8'hAA, s);
        chk("fast_b2b_accept", s - t, 1);
        wait_to(t + 2 + 2 * flen(2) + 3);
        check_frame(2, t + 2, 8'h55);
        check_frame(2, t + 2 + flen(2), 8'hAA);

        train[0] = 1'b1;
        e = cyc + 1;
        repeat (10) tick();
        train[0] = 1'b0;
        l = cyc;
        train_check(0, e, l, t);
        chk("train_idle_busy", {31'd0, busy[0]}, 0);

        train[0] = 1'b1;
        push(0, 8'h5A, t);
        repeat (6) tick();
        train[0] = 1'b0;
        l = cyc;
        train_check(0, t, l, e);
        wait_to(e + 2 + flen(0) + 2);
        check_frame(0, e + 2, 8'h5A);

        push(0, 8'hC3, t);
        s = t + 2;
        wait_to(s + 10);
        train[0] = 1'b1;
        wait_to(s + flen(0) + 8);
        train[0] = 1'b0;
        l = cyc;
        check_frame(0, s, 8'hC3);
        train_check(0, s + flen(0), l, e);

        push(0, 8'h3C, t);
        push(0, 8'($urandom), s);
        push(0, 8'($urandom), s);
        wait_to(t + 2 + 4 * cpb(0) + 2);
        chk("rst_mid_in_data", {31'd0, busy[0]}, 1);
        rst = 1'b1;
        pos = cyc + 1;
        tick();
        chk("rst_mid_line", {31'd0, so[0]}, 1);
        chk("rst_mid_ready", {31'd0, ready[0]}, 0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 0);
        tick();
        rst = 1'b0;
        repeat (120) tick();
        zeros = 0;
        for (int c = pos; c < cyc; c++) if (lg[0][c] !== 1'b1) zeros++;
        chk("rst_no_more_frames", zeros, 0);
        chk("rst_release_ready", {31'd0, ready[0]}, 1);
        chk("rst_release_busy", {31'd0, busy[0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
